// File: rtl/mmu_arb_pkg.sv
// Shared constants and helpers for the MMU arbitrating merge.
package mmu_arb_pkg;

   // Arbitration policies selectable through ARB_MODE.
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_mmu.sv
// Small single-clock FIFO buffering one MMU request port.
// Pushes are refused when full and pops are refused when empty, so the
// caller may drive push/pop without pre-qualifying them.
module sync_fifo_mmu
   import mmu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 88,
   parameter int FIFO_DEPTH = 2
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head
);

   localparam int PTR_W = clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage write; the entry under wr_ptr takes the new payload.
   // NOTE: the data array is deliberately not reset -- validity lives in
   // count, so clearing the payload would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/arb_merge_n_mmu.sv
// N-to-1 arbitrating merge for MMU request paths (walker, TLB refill,
// invalidate queues). Each port feeds a small FIFO; a fixed-priority or
// round-robin arbiter loads one FIFO head per cycle into a registered
// output stage with a valid/ready (drive/free) handshake.
module arb_merge_n_mmu
   import mmu_arb_pkg::*;
#(
   parameter  int NUM_PORTS  = 10,
   parameter  int DATA_WIDTH = 88,
   parameter  int FIFO_DEPTH = 2,
   parameter  int ARB_MODE   = ARB_FIXED,
   localparam int ID_WIDTH   = clog2(NUM_PORTS)
)(
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NUM_PORTS-1:0]            i_drive,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
   output logic [NUM_PORTS-1:0]            o_free,
   output logic                            o_driveNext,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic [ID_WIDTH-1:0]             o_portId,
   input  logic                            i_freeNext,
   output logic                            o_busy
);

   logic [NUM_PORTS-1:0]  fifo_full;
   logic [NUM_PORTS-1:0]  fifo_empty;
   logic [NUM_PORTS-1:0]  fifo_push;
   logic [NUM_PORTS-1:0]  fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_head [NUM_PORTS];

   logic [NUM_PORTS-1:0]  req;
   logic [NUM_PORTS-1:0]  masked_req;
   logic [ID_WIDTH-1:0]   fixed_idx;
   logic [ID_WIDTH-1:0]   masked_idx;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic                  grant_valid;
   logic [DATA_WIDTH-1:0] grant_data;
   logic                  load_en;

   logic                  drive_next_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ID_WIDTH-1:0]   port_id_q;
   logic [ID_WIDTH-1:0]   rr_ptr;

   // Ready comes straight from the registered count: a pop frees the slot
   // only on the following cycle, keeping o_free off the downstream path.
   assign o_free    = ~fifo_full;
   assign fifo_push = i_drive & ~fifo_full;
   assign req       = ~fifo_empty;

   // The output slot may take a new item when empty or being drained now.
   assign load_en = ~drive_next_q | i_freeNext;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      sync_fifo_mmu #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rstn      (rstn),
         .push      (fifo_push[k]),
         .push_data (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .pop       (fifo_pop[k]),
         .full      (fifo_full[k]),
         .empty     (fifo_empty[k]),
         .head      (fifo_head[k])
      );
   end

   // Priority encode: lowest requester overall, and lowest at or above rr_ptr.
   // NOTE: every output of a combinational block is given a default first,
   // so no path through the block can leave a value unassigned (no latch).
   always_comb begin
      masked_req = '0;
      fixed_idx  = '0;
      masked_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         masked_req[k] = req[k] && (ID_WIDTH'(k) >= rr_ptr);
      end
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req[k]) begin
            fixed_idx = ID_WIDTH'(k);
         end
         if (masked_req[k]) begin
            masked_idx = ID_WIDTH'(k);
         end
      end
   end

   // Grant selection, pop generation and winner payload mux.
   always_comb begin
      grant_idx   = fixed_idx;
      grant_valid = load_en & (|req);
      fifo_pop    = '0;
      grant_data  = '0;
      // Round-robin: requests above the pointer first, else wrap to the lowest.
      if ((ARB_MODE == ARB_RR) && (|masked_req)) begin
         grant_idx = masked_idx;
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (grant_valid && (grant_idx == ID_WIDTH'(k))) begin
            fifo_pop[k] = 1'b1;
            grant_data  = fifo_head[k];
         end
      end
   end

   // Output stage and round-robin pointer; everything holds while stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drive_next_q <= 1'b0;
         data_q       <= '0;
         port_id_q    <= '0;
         rr_ptr       <= '0;
      end else if (load_en) begin
         drive_next_q <= grant_valid;
         if (grant_valid) begin
            data_q    <= grant_data;
            port_id_q <= grant_idx;
            rr_ptr    <= (grant_idx == ID_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                 : grant_idx + ID_WIDTH'(1);
         end
      end
   end

   assign o_driveNext = drive_next_q;
   assign o_data      = data_q;
   assign o_portId    = port_id_q;
   assign o_busy      = (|req) | drive_next_q;

endmodule

// File: tb/tb_arb_merge_n_mmu.sv
// Self-checking bench for arb_merge_n_mmu: one fixed-priority and one
// round-robin instance share the same stimulus; each is compared every
// cycle against a queue-based reference model plus directed checks.
`timescale 1ns/1ps
module tb_arb_merge_n_mmu;

   localparam int NP    = 10;
   localparam int DW    = 88;
   localparam int DEPTH = 2;
   localparam int IW    = 4;

   logic             clk;
   logic             rstn;
   logic [NP-1:0]    i_drive;
   logic [NP*DW-1:0] i_data;
   logic             i_freeNext;

   logic [NP-1:0] fix_free, rr_free;
   logic          fix_dn, rr_dn;
   logic [DW-1:0] fix_data, rr_data;
   logic [IW-1:0] fix_id, rr_id;
   logic          fix_busy, rr_busy;

   arb_merge_n_mmu #(
      .NUM_PORTS (NP), .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .ARB_MODE (0)
   ) u_fix (
      .clk (clk), .rstn (rstn), .i_drive (i_drive), .i_data (i_data),
      .o_free (fix_free), .o_driveNext (fix_dn), .o_data (fix_data),
      .o_portId (fix_id), .i_freeNext (i_freeNext), .o_busy (fix_busy)
   );

   arb_merge_n_mmu #(
      .NUM_PORTS (NP), .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .ARB_MODE (1)
   ) u_rr (
      .clk (clk), .rstn (rstn), .i_drive (i_drive), .i_data (i_data),
      .o_free (rr_free), .o_driveNext (rr_dn), .o_data (rr_data),
      .o_portId (rr_id), .i_freeNext (i_freeNext), .o_busy (rr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   int cyc;

   // Reference model: one queue per port per instance (index m*NP+k),
   // plus the output slot and round-robin start position.
   logic [DW-1:0] mq [0:2*NP-1][$];
   logic          m_v    [2];
   logic [DW-1:0] m_data [2];
   int            m_id   [2];
   int            m_rr   [2];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2*NP; i++) mq[i].delete();
      for (int m = 0; m < 2; m++) begin
         m_v[m]    = 1'b0;
         m_data[m] = '0;
         m_id[m]   = 0;
         m_rr[m]   = 0;
      end
   endtask

   // Advance model m across one clock edge with the inputs currently applied.
   task automatic model_step(input int m, input logic [NP-1:0] drv, input logic fn);
      bit acc [NP];
      int win;
      int idx;
      for (int k = 0; k < NP; k++) acc[k] = drv[k] && (mq[m*NP+k].size() < DEPTH);
      if (!m_v[m] || fn) begin
         win = -1;
         for (int i = 0; i < NP; i++) begin
            idx = (m == 1) ? (m_rr[m] + i) % NP : i;
            if (win < 0 && mq[m*NP+idx].size() > 0) win = idx;
         end
         if (win >= 0) begin
            m_data[m] = mq[m*NP+win].pop_front();
            m_id[m]   = win;
            m_v[m]    = 1'b1;
            m_rr[m]   = (win + 1) % NP;
         end else begin
            m_v[m] = 1'b0;
         end
      end
      for (int k = 0; k < NP; k++) begin
         if (acc[k]) mq[m*NP+k].push_back(i_data[k*DW +: DW]);
      end
   endtask

   function automatic logic [NP-1:0] model_free(input int m);
      logic [NP-1:0] f;
      for (int k = 0; k < NP; k++) f[k] = (mq[m*NP+k].size() < DEPTH);
      return f;
   endfunction

   function automatic logic model_busy(input int m);
      logic b;
      b = m_v[m];
      for (int k = 0; k < NP; k++) if (mq[m*NP+k].size() > 0) b = 1'b1;
      return b;
   endfunction

   task automatic check_all();
      check("fix.driveNext", 128'(fix_dn),   128'(m_v[0]));
      check("fix.data",      128'(fix_data), 128'(m_data[0]));
      check("fix.portId",    128'(fix_id),   128'(m_id[0]));
      check("fix.free",      128'(fix_free), 128'(model_free(0)));
      check("fix.busy",      128'(fix_busy), 128'(model_busy(0)));
      check("rr.driveNext",  128'(rr_dn),    128'(m_v[1]));
      check("rr.data",       128'(rr_data),  128'(m_data[1]));
      check("rr.portId",     128'(rr_id),    128'(m_id[1]));
      check("rr.free",       128'(rr_free),  128'(model_free(1)));
      check("rr.busy",       128'(rr_busy),  128'(model_busy(1)));
   endtask

   // One clock: apply inputs, predict, cross the edge, compare #1 later.
   // dmode: 0 = fresh random payloads, 1 = payload equals port index, 2 = hold.
   task automatic cycle(input logic [NP-1:0] drv, input logic fn, input int dmode);
      i_drive    = drv;
      i_freeNext = fn;
      for (int k = 0; k < NP; k++) begin
         if (dmode == 0)      i_data[k*DW +: DW] = {8'(k), 16'(cyc), 32'($urandom), 32'($urandom)};
         else if (dmode == 1) i_data[k*DW +: DW] = DW'(k);
      end
      model_step(0, drv, fn);
      model_step(1, drv, fn);
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".fix.free"}, 128'(fix_free), 128'({NP{1'b1}}));
      check({tag, ".fix.dn"},   128'(fix_dn),   128'(0));
      check({tag, ".fix.busy"}, 128'(fix_busy), 128'(0));
      check({tag, ".fix.data"}, 128'(fix_data), 128'(0));
      check({tag, ".fix.id"},   128'(fix_id),   128'(0));
      check({tag, ".rr.free"},  128'(rr_free),  128'({NP{1'b1}}));
      check({tag, ".rr.dn"},    128'(rr_dn),    128'(0));
      check({tag, ".rr.busy"},  128'(rr_busy),  128'(0));
   endtask

   initial begin
      logic [DW-1:0] item_a, item_b, item_c, item_e;
      int  prev_id;
      bit  seen;
      total = 0;
      bad   = 0;
      cyc   = 0;
      model_reset();

      // Reset held with every port driving: nothing may be taken.
      rstn       = 1'b0;
      i_drive    = '1;
      i_freeNext = 1'b0;
      for (int k = 0; k < NP; k++) i_data[k*DW +: DW] = {8'(k), 80'($urandom)};
      repeat (3) begin
         @(posedge clk);
         #1;
         check_reset_outputs("reset");
      end
      i_drive = '0;
      rstn    = 1'b1;

      // Fixed priority: ports 3, 5, 9 push together, then drain in index order.
      cycle(NP'(10'h228), 1'b1, 1);
      check("fixpri.latency0", 128'(fix_dn), 128'(0));
      cycle('0, 1'b1, 0);
      check("fixpri.dn1", 128'(fix_dn),   128'(1));
      check("fixpri.id1", 128'(fix_id),   128'(3));
      check("fixpri.d1",  128'(fix_data), 128'(3));
      cycle('0, 1'b1, 0);
      check("fixpri.id2", 128'(fix_id),   128'(5));
      check("fixpri.d2",  128'(fix_data), 128'(5));
      cycle('0, 1'b1, 0);
      check("fixpri.id3", 128'(fix_id),   128'(9));
      check("fixpri.d3",  128'(fix_data), 128'(9));
      cycle('0, 1'b1, 0);
      check("fixpri.idle", 128'(fix_dn), 128'(0));

      // Round-robin: all ports busy; grants must step 0,1,..,9,0,...
      seen    = 1'b0;
      prev_id = 0;
      for (int n = 0; n < 25; n++) begin
         cycle('1, 1'b1, 0);
         if (rr_dn) begin
            if (!seen) check("rr.first_id", 128'(rr_id), 128'(0));
            else       check("rr.next_id",  128'(rr_id), 128'((prev_id + 1) % NP));
            seen    = 1'b1;
            prev_id = int'(rr_id);
         end
      end
      check("rr.any_grant", 128'(seen), 128'(1));
      repeat (30) cycle('0, 1'b1, 0);

      // Stall: downstream not ready for 5 cycles while port 2 keeps pushing.
      cycle(NP'(4), 1'b0, 0);
      item_a = i_data[2*DW +: DW];
      cycle(NP'(4), 1'b0, 0);
      item_b = i_data[2*DW +: DW];
      check("stall.valid", 128'(fix_dn),   128'(1));
      check("stall.data0", 128'(fix_data), 128'(item_a));
      cycle(NP'(4), 1'b0, 0);
      item_c = i_data[2*DW +: DW];
      for (int n = 0; n < 3; n++) begin
         if (n > 0) cycle(NP'(4), 1'b0, 0);
         check("stall.hold",  128'(fix_data),    128'(item_a));
         check("stall.free2", 128'(fix_free[2]), 128'(0));
      end
      item_e = i_data[2*DW +: DW];
      // Release: pop and a drive in the same cycle on a full FIFO -> push refused.
      cycle(NP'(4), 1'b1, 2);
      check("release.d_b",   128'(fix_data),    128'(item_b));
      check("release.free2", 128'(fix_free[2]), 128'(1));
      cycle(NP'(4), 1'b1, 2);
      check("release.d_c",   128'(fix_data), 128'(item_c));
      cycle('0, 1'b1, 0);
      check("release.d_e",   128'(fix_data), 128'(item_e));
      check("release.rr_e",  128'(rr_data),  128'(item_e));
      repeat (4) cycle('0, 1'b1, 0);

      // Randomised traffic with random backpressure.
      for (int n = 0; n < 300; n++) begin
         if (n < 150) cycle(NP'($urandom) | NP'($urandom), ($urandom_range(0, 3) != 0), 0);
         else         cycle(NP'($urandom) & NP'($urandom), ($urandom_range(0, 2) != 0), 0);
      end
      repeat (30) cycle('0, 1'b1, 0);

      // Reset mid-stream with items buffered: all of it must vanish at once.
      cycle(NP'(10'h092), 1'b0, 0);
      cycle('0, 1'b0, 0);
      check("midrst.busy_before", 128'(fix_busy), 128'(1));
      rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (6) cycle('0, 1'b1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
